// File: rtl/duty_ramp.sv
// duty_ramp: ramps an 8-bit PWM duty value toward a requested target by a
// programmable step. The duty only changes at PWM period boundaries, which
// keeps the downstream PWM generator glitch-free.
//
// Optional feature: define DUTY_RAMP_DONE_PULSE_EN to add the 'done' output.
// 'done' pulses for one cycle when a ramp reaches its target. It also pulses
// after accepting a target that equals the current duty.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no ramp in progress; a new target can be accepted
// S_RAMP_UP   | duty rises by r_step at each non-held boundary, clamped at target
// S_RAMP_DOWN | duty falls by r_step at each non-held boundary, clamped at target
module duty_ramp #(
    parameter int INIT_DUTY = 0,
    parameter int STEP_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic [7:0]        target_duty,
    input  logic [STEP_W-1:0] step,
    input  logic              hold,
    output logic [7:0]        duty_cycle,
    output logic              period_start,
    output logic              busy
`ifdef DUTY_RAMP_DONE_PULSE_EN
    ,
    output logic              done
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RAMP_DOWN = 2'd2
    } state_t;

    localparam logic [7:0] INIT_VAL = 8'(INIT_DUTY);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [7:0]        r_duty;
    logic [7:0]        r_target;
    logic [STEP_W-1:0] r_step;

    logic              w_tick;
    logic [STEP_W-1:0] w_step_in;
    logic [8:0]        w_step9;
    logic [8:0]        w_up;
    logic [8:0]        w_dn;
    logic              w_up_hit;
    logic              w_dn_hit;

    // A boundary is the edge where the period counter wraps 255 -> 0.
    // Hold masks boundaries so ramp progress freezes while the counter runs.
    assign w_tick    = (r_cnt == 8'hFF) & ~hold;
    assign w_step_in = (step == '0) ? STEP_W'(1) : step;
    assign w_step9   = 9'(r_step);

    // Nine-bit arithmetic: the carry/borrow bit flags overshoot past 255 / 0.
    assign w_up      = {1'b0, r_duty} + w_step9;
    assign w_dn      = {1'b0, r_duty} - w_step9;
    assign w_up_hit  = (w_up >= {1'b0, r_target});
    assign w_dn_hit  = w_dn[8] | (w_dn[7:0] <= r_target);

    assign target_ready = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign period_start = (r_cnt == 8'd0);
    assign duty_cycle   = r_duty;

    // Free-running PWM period counter.
    // It is aligned with a downstream counter released from reset on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Ramp FSM: accept targets in idle, step the duty at boundaries otherwise.
    // An acceptance coincident with a boundary only changes state here, so the
    // first duty step lands on the following boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_duty   <= INIT_VAL;
            r_target <= INIT_VAL;
            r_step   <= STEP_W'(1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (target_valid) begin
                        r_target <= target_duty;
                        r_step   <= w_step_in;
                        if (target_duty > r_duty) begin
                            r_state <= S_RAMP_UP;
                        end else if (target_duty < r_duty) begin
                            r_state <= S_RAMP_DOWN;
                        end
                    end
                end
                S_RAMP_UP: begin
                    if (w_tick) begin
                        if (w_up_hit) begin
                            r_duty  <= r_target;
                            r_state <= S_IDLE;
                        end else begin
                            r_duty <= w_up[7:0];
                        end
                    end
                end
                S_RAMP_DOWN: begin
                    if (w_tick) begin
                        if (w_dn_hit) begin
                            r_duty  <= r_target;
                            r_state <= S_IDLE;
                        end else begin
                            r_duty <= w_dn[7:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DUTY_RAMP_DONE_PULSE_EN
    logic r_done;
    logic w_accept_eq;
    logic w_reach;

    assign w_accept_eq = (r_state == S_IDLE) & target_valid & (target_duty == r_duty);
    assign w_reach     = w_tick & (((r_state == S_RAMP_UP) & w_up_hit) |
                                   ((r_state == S_RAMP_DOWN) & w_dn_hit));
    assign done        = r_done;

    // One-cycle completion pulse, registered alongside the final duty update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_accept_eq | w_reach;
        end
    end
`endif

endmodule

// File: tb/tb_duty_ramp.sv
// Testbench for duty_ramp. The stimulus process queues the expected duty and
// busy value for each upcoming period_start. A monitor checks those values at
// each period_start.
module tb_duty_ramp;

    typedef struct {
        logic [7:0] duty;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       target_valid;
    logic       target_ready;
    logic [7:0] target_duty;
    logic [7:0] step;
    logic       hold;
    logic [7:0] duty_cycle;
    logic       period_start;
    logic       busy;
`ifdef DUTY_RAMP_DONE_PULSE_EN
    logic       done;
`endif

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    duty_ramp #(.INIT_DUTY(0), .STEP_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .target_duty  (target_duty),
        .step         (step),
        .hold         (hold),
        .duty_cycle   (duty_cycle),
        .period_start (period_start),
        .busy         (busy)
`ifdef DUTY_RAMP_DONE_PULSE_EN
        ,
        .done         (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Scoreboard monitor: one expectation is consumed per period_start.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && period_start && q.size() > 0) begin
            e = q.pop_front();
            check("sb_duty", int'(duty_cycle), int'(e.duty));
            check("sb_busy", int'(busy), int'(e.busy));
`ifdef DUTY_RAMP_DONE_PULSE_EN
            check("sb_done", int'(done), int'(!e.busy));
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push(input int d, input bit b);
        exp_t e;
        e.duty = 8'(d);
        e.busy = b;
        q.push_back(e);
    endtask

    // Wait until every queued expectation has been consumed.
    task automatic drain(input int periods);
        int k;
        k = 0;
        while (q.size() > 0 && k < periods * 256 + 16) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    // Reach a negedge in the idle state that is not a period_start.
    // Expectations pushed here cannot be consumed by a stale pulse.
    task automatic sync_mid();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((period_start || !target_ready) && k < 2000);
        check("sync_timeout", int'(k >= 2000), 0);
    endtask

    task automatic issue(input int tgt, input int stp);
        target_valid = 1'b1;
        target_duty  = 8'(tgt);
        step         = 8'(stp);
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    initial begin
        int k;
        reset_n      = 1'b0;
        target_valid = 1'b0;
        target_duty  = 8'd0;
        step         = 8'd0;
        hold         = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_duty", int'(duty_cycle), 0);
        check("rst_ready", int'(target_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_pstart", int'(period_start), 1);
`ifdef DUTY_RAMP_DONE_PULSE_EN
        check("rst_done", int'(done), 0);
`endif
        reset_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < 300);
        check("first_pstart_cycles", k, 256);

        // Ramp up 0 -> 64 by 16.
        sync_mid();
        push(16, 1); push(32, 1); push(48, 1); push(64, 0);
        issue(64, 16);
        check("up_ready_after_accept", int'(target_ready), 0);
        drain(5);
        check("up_ready_end", int'(target_ready), 1);

        // Ramp down 64 -> 0 by 20, clamped at 0.
        sync_mid();
        push(44, 1); push(24, 1); push(4, 1); push(0, 0);
        issue(0, 20);
        drain(5);

        // Step 0 behaves as step 1.
        sync_mid();
        push(1, 1); push(2, 1); push(3, 0);
        issue(3, 0);
        drain(4);

        // 3 -> 250 by 15, then 250 -> 255 in one clamped step.
        sync_mid();
        for (int i = 1; i <= 17; i++) begin
            if (3 + 15 * i >= 250) push(250, 0);
            else push(3 + 15 * i, 1);
        end
        issue(250, 15);
        drain(18);
        sync_mid();
        push(255, 0);
        issue(255, 15);
        drain(2);

        // Hold across two boundaries mid-ramp: 255 -> 191 by 16.
        sync_mid();
        push(239, 1); push(223, 1);
        issue(191, 16);
        drain(3);
        hold = 1'b1;
        push(223, 1); push(223, 1);
        drain(3);
        hold = 1'b0;
        push(207, 1); push(191, 0);
        drain(3);

        // Accept on the boundary cycle; the first step lands one boundary later.
        // A target_valid offered mid-ramp must be ignored.
        sync_mid();
        k = 0;
        while (!period_start && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (255) @(negedge clk);
        push(191, 1); push(195, 1); push(199, 1); push(200, 0);
        issue(200, 4);
        repeat (4) @(negedge clk);
        target_valid = 1'b1;
        target_duty  = 8'd0;
        step         = 8'd50;
        repeat (5) @(negedge clk);
        target_valid = 1'b0;
        drain(5);

        // No-op target equal to current duty.
        sync_mid();
        issue(200, 5);
        check("noop_ready", int'(target_ready), 1);
        check("noop_busy", int'(busy), 0);
`ifdef DUTY_RAMP_DONE_PULSE_EN
        check("noop_done", int'(done), 1);
`endif
        @(negedge clk);
        check("noop_duty", int'(duty_cycle), 200);

        // Abort mid-ramp at duty 48 with asynchronous reset.
        reset_n = 1'b0;
        #1;
        check("rst_pulse_duty", int'(duty_cycle), 0);
        @(negedge clk);
        reset_n = 1'b1;
        sync_mid();
        push(16, 1); push(32, 1); push(48, 1);
        issue(128, 16);
        drain(4);
        check("abort_pre_duty", int'(duty_cycle), 48);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_duty", int'(duty_cycle), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(target_ready), 1);
        check("abort_queue_empty", q.size(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
